// File: rtl/stream_rr_arbiter_if.sv
// Stream bundle between NREQ upstream requesters, the arbiter and one downstream sink.
// The arbiter connects through the slave modport. The master modport is the opposite view.
interface stream_rr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8
);
   localparam int SW = $clog2(NREQ);

   // Handshake: a beat moves on a rising edge when valid and ready are both high
   // on that side of the arbiter. Upstream is i_valid[k]/o_ready[k]; downstream is o_valid/i_ready.
   // Once o_valid is raised, o_data/o_last/o_src hold until i_ready is seen high.
   logic [NREQ-1:0]    i_valid;
   logic [NREQ-1:0]    o_ready;
   logic [NREQ*DW-1:0] i_data;
   logic [NREQ-1:0]    i_last;
   logic               o_valid;
   logic               i_ready;
   logic [DW-1:0]      o_data;
   logic               o_last;
   logic [SW-1:0]      o_src;
   logic               dbg_locked;   // lock FSM state, 1 = LOCKED

   modport slave (
      input  i_valid, i_data, i_last, i_ready,
      output o_ready, o_valid, o_data, o_last, o_src, dbg_locked
   );

   modport master (
      output i_valid, i_data, i_last, i_ready,
      input  o_ready, o_valid, o_data, o_last, o_src, dbg_locked
   );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that merges NREQ valid/ready streams into one registered output stage.
// With OPT_PKTLOCK=1, the grant is held from the first beat of a packet through its i_last beat.
module stream_rr_arbiter #(
   parameter int NREQ         = 4,
   parameter int DW           = 8,
   parameter int OPT_PKTLOCK  = 1,
   parameter int OPT_LOWPOWER = 0
) (
   input logic                i_clk,
   input logic                i_reset,
   stream_rr_arbiter_if.slave bus
);
   localparam int SW = $clog2(NREQ);
   localparam logic [SW-1:0] LAST_IDX = SW'(NREQ - 1);

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } lock_state_t;

   lock_state_t   state_q, state_d;
   logic [SW-1:0] lock_idx_q, lock_idx_d;
   logic [SW-1:0] ptr_q, ptr_d;

   logic [SW-1:0] rr_idx;
   logic          rr_found;
   logic [SW-1:0] cur;
   logic          cur_valid;
   logic          cur_last;
   logic [DW-1:0] cur_data;
   logic          adv;
   logic          grant;
   logic          accept;
   logic          ends_grant;
   logic [NREQ-1:0] ready;

   logic          o_valid_q;
   logic          o_last_q;
   logic [DW-1:0] o_data_q;
   logic [SW-1:0] o_src_q;

   // Round-robin search: first valid requester starting at ptr, wrapping modulo NREQ.
   always_comb begin
      int k;
      k        = 0;
      rr_found = 1'b0;
      rr_idx   = ptr_q;
      for (int n = 0; n < NREQ; n++) begin
         k = int'(ptr_q) + n;
         if (k >= NREQ) k = k - NREQ;
         if (!rr_found && bus.i_valid[SW'(k)]) begin
            rr_found = 1'b1;
            rr_idx   = SW'(k);
         end
      end
   end

   // Current selection, its beat, and the handshake decision for this cycle.
   always_comb begin
      cur       = (state_q == ST_LOCKED) ? lock_idx_q : rr_idx;
      cur_valid = 1'b0;
      cur_last  = 1'b0;
      cur_data  = '0;
      for (int n = 0; n < NREQ; n++) begin
         if (cur == SW'(n)) begin
            cur_valid = bus.i_valid[n];
            cur_last  = bus.i_last[n];
            cur_data  = bus.i_data[n*DW +: DW];
         end
      end
      adv = !o_valid_q || bus.i_ready;
      // While locked, ready is offered to the owner even during its bubbles.
      grant = adv && ((state_q == ST_LOCKED) || rr_found);
      ready = '0;
      for (int n = 0; n < NREQ; n++) begin
         if (grant && (cur == SW'(n))) ready[n] = 1'b1;
      end
      accept     = grant && cur_valid;
      ends_grant = accept && ((OPT_PKTLOCK == 0) || cur_last);
   end

   // Lock FSM next state and round-robin pointer update.
   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      ptr_d      = ptr_q;
      if (OPT_PKTLOCK != 0) begin
         case (state_q)
            ST_UNLOCKED: begin
               if (accept && !cur_last) begin
                  state_d    = ST_LOCKED;
                  lock_idx_d = cur;
               end
            end
            ST_LOCKED: begin
               if (accept && cur_last) state_d = ST_UNLOCKED;
            end
            default: state_d = ST_UNLOCKED;
         endcase
      end
      if (ends_grant) ptr_d = (cur == LAST_IDX) ? '0 : cur + SW'(1);
   end

   // Lock FSM and pointer registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= ST_UNLOCKED;
         lock_idx_q <= '0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
         ptr_q      <= ptr_d;
      end
   end

   // Output stage: load on accept, empty on an idle advance, hold while stalled.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_last_q  <= 1'b0;
         o_src_q   <= '0;
      end else if (accept) begin
         o_valid_q <= 1'b1;
         o_data_q  <= cur_data;
         o_last_q  <= cur_last;
         o_src_q   <= cur;
      end else if (adv) begin
         o_valid_q <= 1'b0;
         if (OPT_LOWPOWER != 0) begin
            o_data_q <= '0;
            o_last_q <= 1'b0;
         end
      end
   end

   assign bus.o_ready    = ready;
   assign bus.o_valid    = o_valid_q;
   assign bus.o_data     = o_data_q;
   assign bus.o_last     = o_last_q;
   assign bus.o_src      = o_src_q;
   assign bus.dbg_locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: one locking and one non-locking instance sharing clock and reset.
module tb_stream_rr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [7:0] exp_q[$];

   // Clock and reset
   always #5 clk = ~clk;

   stream_rr_arbiter_if #(.NREQ(4), .DW(8)) bus_l();
   stream_rr_arbiter_if #(.NREQ(4), .DW(8)) bus_n();

   stream_rr_arbiter #(.NREQ(4), .DW(8), .OPT_PKTLOCK(1), .OPT_LOWPOWER(0)) dut_lock (
      .i_clk(clk), .i_reset(rst), .bus(bus_l)
   );
   stream_rr_arbiter #(.NREQ(4), .DW(8), .OPT_PKTLOCK(0), .OPT_LOWPOWER(0)) dut_nolock (
      .i_clk(clk), .i_reset(rst), .bus(bus_n)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Driver tasks
   task automatic drive(input bit which, input logic [3:0] v, input logic [3:0] l,
                        input logic [31:0] d, input logic rdy);
      if (which) begin
         bus_n.i_valid = v; bus_n.i_last = l; bus_n.i_data = d; bus_n.i_ready = rdy;
      end else begin
         bus_l.i_valid = v; bus_l.i_last = l; bus_l.i_data = d; bus_l.i_ready = rdy;
      end
   endtask

   task automatic idle_all();
      drive(1'b0, 4'b0, 4'b0, 32'h0, 1'b1);
      drive(1'b1, 4'b0, 4'b0, 32'h0, 1'b1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_all();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   // One cycle: drive at negedge, check ready before the edge, check the output stage after it.
   task automatic cyc(input string tag, input bit which, input logic [3:0] v, input logic [3:0] l,
                      input logic [31:0] d, input logic rdy, input logic [3:0] e_ready,
                      input logic e_valid, input logic [1:0] e_src, input logic [7:0] e_data,
                      input logic e_last);
      @(negedge clk);
      drive(which, v, l, d, rdy);
      #1;
      check({tag, "_ready"}, which ? bus_n.o_ready : bus_l.o_ready, e_ready);
      tick();
      check({tag, "_valid"}, which ? bus_n.o_valid : bus_l.o_valid, e_valid);
      check({tag, "_src"},   which ? bus_n.o_src   : bus_l.o_src,   e_src);
      check({tag, "_data"},  which ? bus_n.o_data  : bus_l.o_data,  e_data);
      check({tag, "_last"},  which ? bus_n.o_last  : bus_l.o_last,  e_last);
   endtask

   initial begin
      logic [7:0] byte_v;
      logic [1:0] t2_src[6];
      t2_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      idle_all();

      // Reset state
      do_reset();
      check("rst_valid",  bus_l.o_valid, 0);
      check("rst_data",   bus_l.o_data, 0);
      check("rst_last",   bus_l.o_last, 0);
      check("rst_src",    bus_l.o_src, 0);
      check("rst_locked", bus_l.dbg_locked, 0);
      check("rst_ready",  bus_l.o_ready, 0);
      check("rst_n_valid", bus_n.o_valid, 0);

      // 1: single requester, back-to-back single-beat packets
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         byte_v = 8'(8'h10 + b);
         drive(1'b0, 4'b0010, 4'b0010, {16'h0, byte_v, 8'h0}, 1'b1);
         exp_q.push_back(byte_v);
         #1;
         check("t1_ready", bus_l.o_ready, 4'b0010);
         tick();
         check("t1_valid", bus_l.o_valid, 1);
         check("t1_src",   bus_l.o_src, 1);
         check("t1_data",  bus_l.o_data, exp_q.pop_front());
      end
      cyc("t1_idle", 1'b0, 4'b0, 4'b0, 32'h0, 1'b1, 4'b0, 1'b0, 2'd1, 8'h17, 1'b1);

      // 2: all valid, single-beat packets, wrap
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(1'b0, 4'b1111, 4'b1111, 32'h23222120, 1'b1);
         #1;
         check("t2_ready", bus_l.o_ready, 4'b0001 << t2_src[i]);
         check("t2_onehot", $countones(bus_l.o_ready), 1);
         tick();
         check("t2_src",  bus_l.o_src, t2_src[i]);
         check("t2_data", bus_l.o_data, 8'h20 + 8'(t2_src[i]));
      end

      // 3: locked 3-beat packet with a bubble, competitor blocked
      do_reset();
      cyc("t3_b1",   1'b0, 4'b0011, 4'b0010, 32'h00004030, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h30, 1'b0);
      check("t3_locked", bus_l.dbg_locked, 1);
      cyc("t3_bub",  1'b0, 4'b0010, 4'b0010, 32'h00004030, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h30, 1'b0);
      cyc("t3_b2",   1'b0, 4'b0011, 4'b0010, 32'h00004031, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h31, 1'b0);
      cyc("t3_b3",   1'b0, 4'b0011, 4'b0011, 32'h00004032, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h32, 1'b1);
      check("t3_unlocked", bus_l.dbg_locked, 0);
      cyc("t3_r1",   1'b0, 4'b0010, 4'b0010, 32'h00004000, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h40, 1'b1);
      cyc("t3_idle", 1'b0, 4'b0000, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 2'd1, 8'h40, 1'b1);

      // 4: downstream stall holds the beat, no early grant
      do_reset();
      cyc("t4_load", 1'b0, 4'b0001, 4'b0001, 32'h000000A5, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA5, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc("t4_stall", 1'b0, (i % 2 == 1) ? 4'b0100 : 4'b1110, 4'b1111, 32'h53525150, 1'b0,
             4'b0000, 1'b1, 2'd0, 8'hA5, 1'b1);
      end
      cyc("t4_rel",  1'b0, 4'b1110, 4'b1111, 32'h53525150, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h51, 1'b1);
      cyc("t4_idle", 1'b0, 4'b0000, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 2'd1, 8'h51, 1'b1);

      // 5: reset while locked on req2
      do_reset();
      cyc("t5_lock", 1'b0, 4'b0100, 4'b0000, 32'h00620000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h62, 1'b0);
      check("t5_locked", bus_l.dbg_locked, 1);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 4'b0101, 4'b0001, 32'h00620060, 1'b1);
      tick();
      check("t5_rst_valid",  bus_l.o_valid, 0);
      check("t5_rst_data",   bus_l.o_data, 0);
      check("t5_rst_src",    bus_l.o_src, 0);
      check("t5_rst_locked", bus_l.dbg_locked, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("t5_ready", bus_l.o_ready, 4'b0001);
      tick();
      check("t5_valid", bus_l.o_valid, 1);
      check("t5_src",   bus_l.o_src, 0);
      check("t5_data",  bus_l.o_data, 8'h60);

      // 6: no packet lock, 2-beat packets interleave
      do_reset();
      cyc("t6_c1", 1'b1, 4'b0011, 4'b0000, 32'h00008070, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h70, 1'b0);
      check("t6_nolock", bus_n.dbg_locked, 0);
      cyc("t6_c2", 1'b1, 4'b0011, 4'b0001, 32'h00008071, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h80, 1'b0);
      cyc("t6_c3", 1'b1, 4'b0011, 4'b0011, 32'h00008171, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h71, 1'b1);
      cyc("t6_c4", 1'b1, 4'b0010, 4'b0010, 32'h00008100, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h81, 1'b1);

      // Final report
      check("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end
endmodule
